hex_ascii_parser: RTL and testbench

Streaming parser that takes ASCII hex characters one per cycle, for example from the debug UART receiver or a command buffer. It assembles them into a binary word of DIGITS nibbles and hands the word to the downstream consumer, such as the debug register/memory write path of the pipelined processor. It is the inverse of the binary-to-hex-ASCII display path. Both sides use valid/ready handshakes. Invalid characters raise an error pulse and discard the partial word.

---
 rtl/hex_ascii_pkg.sv | 26 ++
 rtl/ascii_hex_decode.sv | 30 +++
 rtl/hex_ascii_parser.sv | 97 +++++++++
 tb/tb_hex_ascii_parser.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_ascii_pkg.sv
// rtl/hex_ascii_pkg.sv - shared constants and types for the hex ASCII parser
package hex_ascii_pkg;

    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_UA      = 8'h41;
    localparam logic [7:0] ASCII_UF      = 8'h46;
    localparam logic [7:0] ASCII_LA      = 8'h61;
    localparam logic [7:0] ASCII_LF      = 8'h66;
    localparam logic [7:0] ASCII_SP      = 8'h20;
    localparam logic [7:0] ASCII_COMMA   = 8'h2C;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF_CHAR = 8'h0A;

    typedef enum logic [1:0] {
        CC_HEX,
        CC_SEP,
        CC_BAD
    } char_class_t;

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } parser_state_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// rtl/ascii_hex_decode.sv - combinational ASCII character to nibble/class decoder
// ascii_char : ASCII code to classify
// nibble     : hex value 0-15 (0 when cls is not CC_HEX)
// cls        : CC_HEX, CC_SEP or CC_BAD
module ascii_hex_decode
    import hex_ascii_pkg::*;
(
    input  logic [7:0]  ascii_char,
    output logic [3:0]  nibble,
    output char_class_t cls
);

    always_comb begin
        nibble = 4'h0;
        cls    = CC_BAD;
        if (ascii_char >= ASCII_0 && ascii_char <= ASCII_9) begin
            nibble = ascii_char[3:0];
            cls    = CC_HEX;
        end else if ((ascii_char >= ASCII_UA && ascii_char <= ASCII_UF) ||
                     (ascii_char >= ASCII_LA && ascii_char <= ASCII_LF)) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 10..15
            nibble = ascii_char[3:0] + 4'd9;
            cls    = CC_HEX;
        end else if (ascii_char == ASCII_SP || ascii_char == ASCII_COMMA ||
                     ascii_char == ASCII_CR || ascii_char == ASCII_LF_CHAR) begin
            cls    = CC_SEP;
        end
    end

endmodule

// File: rtl/hex_ascii_parser.sv
// rtl/hex_ascii_parser.sv - streaming ASCII hex to binary word parser
// clk, rst             : clock, synchronous active-high reset
// char_in/char_valid/char_ready : character input handshake
// word_out/word_valid/word_ready: assembled word output handshake
// err                  : one-cycle pulse after an invalid character is consumed
// digit_count          : nibbles currently accumulated
module hex_ascii_parser
    import hex_ascii_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 char_in,
    input  logic                       char_valid,
    output logic                       char_ready,
    output logic [4*DIGITS-1:0]        word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       err,
    output logic [$clog2(DIGITS+1)-1:0] digit_count
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    parser_state_t state;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_shift;
    logic [3:0]    nibble;
    char_class_t   cls;

    ascii_hex_decode u_decode (
        .ascii_char (char_in),
        .nibble     (nibble),
        .cls        (cls)
    );

    // Shift form stays legal for DIGITS=1, where a part-select would not
    assign acc_shift  = (acc << 4) | W'(nibble);

    // Ready comes straight from the state flop: no input-to-output path
    assign char_ready = (state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ACCUM;
            acc         <= '0;
            digit_count <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == ST_ACCUM) begin
                if (char_valid) begin
                    case (cls)
                        CC_HEX: begin
                            if (digit_count == LAST_DIGIT) begin
                                word_out    <= acc_shift;
                                word_valid  <= 1'b1;
                                acc         <= '0;
                                digit_count <= '0;
                                state       <= ST_HOLD;
                            end else begin
                                acc         <= acc_shift;
                                digit_count <= digit_count + CW'(1);
                            end
                        end
                        CC_SEP: begin
                            // A separator with nothing accumulated is a no-op
                            if (digit_count != '0) begin
                                word_out    <= acc;
                                word_valid  <= 1'b1;
                                acc         <= '0;
                                digit_count <= '0;
                                state       <= ST_HOLD;
                            end
                        end
                        default: begin
                            err         <= 1'b1;
                            acc         <= '0;
                            digit_count <= '0;
                        end
                    endcase
                end
            end else begin
                if (word_ready) begin
                    word_valid <= 1'b0;
                    state      <= ST_ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_ascii_parser.sv
// tb/tb_hex_ascii_parser.sv - self-checking bench for hex_ascii_parser
module tb_hex_ascii_parser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  word_out;
    logic        word_valid;
    logic        word_ready;
    logic        err;
    logic [1:0]  digit_count;

    logic [7:0]  char_in8;
    logic        char_valid8;
    logic        char_ready8;
    logic [31:0] word_out8;
    logic        word_valid8;
    logic        word_ready8;
    logic        err8;
    logic [3:0]  digit_count8;

    hex_ascii_parser #(.DIGITS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .err         (err),
        .digit_count (digit_count)
    );

    hex_ascii_parser #(.DIGITS(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .char_in     (char_in8),
        .char_valid  (char_valid8),
        .char_ready  (char_ready8),
        .word_out    (word_out8),
        .word_valid  (word_valid8),
        .word_ready  (word_ready8),
        .err         (err8),
        .digit_count (digit_count8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change at the falling edge, so 2 time units later they
    // and the DUT outputs are stable up to the next rising edge.
    logic [7:0] got_q[$];
    int         err_seen;
    bit         rand_ready;

    always @(negedge clk) begin
        if (rand_ready) word_ready = ($urandom_range(0, 2) != 0);
        #2;
        if (!rst) begin
            if (word_valid && word_ready) got_q.push_back(word_out);
            if (err) err_seen++;
        end
    end

    task automatic send_char(input logic [7:0] c);
        bit taken;
        int n;
        n          = 0;
        char_in    = c;
        char_valid = 1'b1;
        do begin
            taken = char_ready;
            @(negedge clk);
            n++;
        end while (!taken && n < 200);
        if (!taken) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=char_ready_low required=consumed char=0x%0h", c);
        end
        char_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] c);
        bit taken;
        int n;
        n           = 0;
        char_in8    = c;
        char_valid8 = 1'b1;
        do begin
            taken = char_ready8;
            @(negedge clk);
            n++;
        end while (!taken && n < 200);
        if (!taken) begin
            checks++;
            failures++;
            $display("FAIL send8_timeout actual=char_ready_low required=consumed char=0x%0h", c);
        end
        char_valid8 = 1'b0;
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        got_q.delete();
        err_seen   = 0;
    endtask

    // Reference classification straight from the character rules
    function automatic int class_of(input logic [7:0] c, output logic [3:0] v);
        int ci;
        ci = int'(c);
        v  = 4'h0;
        if (ci >= 48 && ci <= 57)  begin v = 4'(ci - 48); return 0; end
        if (ci >= 65 && ci <= 70)  begin v = 4'(ci - 55); return 0; end
        if (ci >= 97 && ci <= 102) begin v = 4'(ci - 87); return 0; end
        if (ci == 32 || ci == 44 || ci == 13 || ci == 10) return 1;
        return 2;
    endfunction

    typedef struct {
        string            s;
        int               nw;
        logic [2:0][7:0]  w;
        int               nerr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        string      hexset;
        logic [7:0] seps[4];
        logic [7:0] sent[$];
        logic [7:0] exp_q[$];
        int         exp_err;

        rst         = 1'b1;
        char_in     = 8'h00;
        char_valid  = 1'b0;
        word_ready  = 1'b1;
        char_in8    = 8'h00;
        char_valid8 = 1'b0;
        word_ready8 = 1'b1;
        rand_ready  = 1'b0;
        err_seen    = 0;

        vecs[0] = '{s:"3F",        nw:1, w:{8'h00, 8'h00, 8'h3F}, nerr:0};
        vecs[1] = '{s:"ab7 ",      nw:2, w:{8'h00, 8'h07, 8'hAB}, nerr:0};
        vecs[2] = '{s:"  ",        nw:0, w:{8'h00, 8'h00, 8'h00}, nerr:0};
        vecs[3] = '{s:"1G25",      nw:1, w:{8'h00, 8'h00, 8'h25}, nerr:1};
        vecs[4] = '{s:"ff,0\n",    nw:2, w:{8'h00, 8'h00, 8'hFF}, nerr:0};
        vecs[5] = '{s:"x#",        nw:0, w:{8'h00, 8'h00, 8'h00}, nerr:2};
        vecs[6] = '{s:"C\015",     nw:1, w:{8'h00, 8'h00, 8'h0C}, nerr:0};
        vecs[7] = '{s:"12,9Z",     nw:1, w:{8'h00, 8'h00, 8'h12}, nerr:1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_word_out",    32'(word_out),    32'h0);
        check("rst_word_valid",  32'(word_valid),  32'h0);
        check("rst_err",         32'(err),         32'h0);
        check("rst_char_ready",  32'(char_ready),  32'h1);
        check("rst_digit_count", 32'(digit_count), 32'h0);

        // Table-driven vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            word_ready = 1'b1;
            for (int i = 0; i < vecs[v].s.len(); i++) send_char(vecs[v].s[i]);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_word_count", v), 32'(got_q.size()), 32'(vecs[v].nw));
            check($sformatf("vec%0d_err_count", v), 32'(err_seen), 32'(vecs[v].nerr));
            for (int i = 0; i < vecs[v].nw && i < got_q.size(); i++)
                check($sformatf("vec%0d_word%0d", v, i), 32'(got_q[i]), 32'(vecs[v].w[i]));
        end

        // Latency: word_valid the cycle after the last digit, for one cycle
        do_reset();
        word_ready = 1'b1;
        send_char("3");
        send_char("F");
        check("lat_word_valid", 32'(word_valid), 32'h1);
        check("lat_word_out",   32'(word_out),   32'h3F);
        check("lat_err",        32'(err),        32'h0);
        @(negedge clk);
        check("lat_valid_drop", 32'(word_valid), 32'h0);

        // Error pulse timing
        do_reset();
        send_char("1");
        check("err_before",   32'(err),         32'h0);
        check("err_count1",   32'(digit_count), 32'h1);
        send_char("G");
        check("err_pulse",    32'(err),         32'h1);
        check("err_count0",   32'(digit_count), 32'h0);
        @(negedge clk);
        check("err_one_cycle", 32'(err),        32'h0);
        send_char("2");
        send_char("5");
        repeat (2) @(negedge clk);
        check("err_next_words", 32'(got_q.size()), 32'h1);
        if (got_q.size() > 0) check("err_next_word", 32'(got_q[0]), 32'h25);

        // Backpressure: held word, blocked character
        do_reset();
        word_ready = 1'b0;
        send_char("9");
        send_char("9");
        char_in    = "4";
        char_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_char_ready%0d", i), 32'(char_ready),  32'h0);
            check($sformatf("bp_valid%0d", i),      32'(word_valid),  32'h1);
            check($sformatf("bp_word%0d", i),       32'(word_out),    32'h99);
            if (i < 2) @(negedge clk);
        end
        word_ready = 1'b1;
        @(negedge clk);
        check("bp_released_valid", 32'(word_valid),  32'h0);
        check("bp_released_ready", 32'(char_ready),  32'h1);
        check("bp_not_consumed",   32'(digit_count), 32'h0);
        @(negedge clk);
        char_valid = 1'b0;
        check("bp_consumed_4",     32'(digit_count), 32'h1);
        check("bp_accepted",       32'(got_q.size()), 32'h1);
        if (got_q.size() > 0) check("bp_accepted_word", 32'(got_q[0]), 32'h99);

        // Reset mid-word
        do_reset();
        send_char("1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_word_out",   32'(word_out),    32'h0);
        check("mid_rst_word_valid", 32'(word_valid),  32'h0);
        check("mid_rst_err",        32'(err),         32'h0);
        check("mid_rst_ready",      32'(char_ready),  32'h1);
        check("mid_rst_count",      32'(digit_count), 32'h0);
        got_q.delete();
        send_char("2");
        send_char("3");
        repeat (2) @(negedge clk);
        check("mid_rst_words", 32'(got_q.size()), 32'h1);
        if (got_q.size() > 0) check("mid_rst_word", 32'(got_q[0]), 32'h23);

        // DIGITS=8 instance
        begin
            string s1;
            s1 = "DEADbeef";
            for (int i = 0; i < s1.len(); i++) send8(s1[i]);
            check("d8_valid", 32'(word_valid8), 32'h1);
            check("d8_word",  word_out8,        32'hDEADBEEF);
            check("d8_count", 32'(digit_count8), 32'h0);
            @(negedge clk);
            s1 = "12\015";
            for (int i = 0; i < s1.len(); i++) send8(s1[i]);
            check("d8_short_valid", 32'(word_valid8), 32'h1);
            check("d8_short_word",  word_out8,        32'h00000012);
            check("d8_err",         32'(err8),        32'h0);
        end

        // Randomized stream against the reference model
        hexset = "0123456789abcdefABCDEF";
        seps   = '{8'h20, 8'h2C, 8'h0D, 8'h0A};
        do_reset();
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int         r;
            logic [7:0] c;
            logic [3:0] dv;
            r = $urandom_range(0, 9);
            if (r < 6)      c = hexset[$urandom_range(0, 21)];
            else if (r < 8) c = seps[$urandom_range(0, 3)];
            else begin
                c = 8'($urandom_range(0, 255));
                if (class_of(c, dv) != 2) c = "g";
            end
            sent.push_back(c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_char(c);
        end
        rand_ready = 1'b0;
        word_ready = 1'b1;
        repeat (4) @(negedge clk);

        begin
            int         nd;
            int         acc;
            logic [3:0] dv;
            nd      = 0;
            acc     = 0;
            exp_err = 0;
            foreach (sent[k]) begin
                case (class_of(sent[k], dv))
                    0: begin
                        acc = acc * 16 + int'(dv);
                        nd++;
                        if (nd == 2) begin exp_q.push_back(8'(acc)); acc = 0; nd = 0; end
                    end
                    1: if (nd > 0) begin exp_q.push_back(8'(acc)); acc = 0; nd = 0; end
                    default: begin exp_err++; acc = 0; nd = 0; end
                endcase
            end
        end
        check("rand_word_count", 32'(got_q.size()), 32'(exp_q.size()));
        check("rand_err_count",  32'(err_seen),     32'(exp_err));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
